// File: rtl/shift_pkg.sv
// shift_pkg: op/source/state encodings and defaults shared by the shift unit files
package shift_pkg;
   localparam int IMM_SHIFT_DEF = 16;
   typedef enum logic [2:0] {
      OP_SLL = 3'd0,
      OP_SRL = 3'd1,
      OP_SRA = 3'd2,
      OP_ROL = 3'd3,
      OP_ROR = 3'd4
   } shift_op_e;
   typedef enum logic [1:0] {
      SRC_AB   = 2'd0,
      SRC_BIMM = 2'd1,
      SRC_LUI  = 2'd2,
      SRC_BA   = 2'd3
   } shift_src_e;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } shift_state_e;
   function automatic logic op_illegal(input logic [2:0] op);
      return op > OP_ROR;
   endfunction
endpackage

// File: rtl/shift_unit_if.sv
// shift_unit_if: request/response bundle between the datapath control and shift_unit
interface shift_unit_if #(parameter int WIDTH = 32);
   logic             start_i;
   logic [1:0]       src_sel_i;
   logic [2:0]       op_i;
   logic [WIDTH-1:0] a_i;
   logic [WIDTH-1:0] b_i;
   logic [15:0]      imm_i;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] result_o;
   logic             illegal_o;
   modport master (
      output start_i, src_sel_i, op_i, a_i, b_i, imm_i,
      input  busy_o, done_o, result_o, illegal_o
   );
   modport slave (
      input  start_i, src_sel_i, op_i, a_i, b_i, imm_i,
      output busy_o, done_o, result_o, illegal_o
   );
endinterface

// File: rtl/shift_step.sv
// shift_step: combinational shift of WIDTH bits by k (0..STEP) for one op and fill bit
module shift_step import shift_pkg::*; #(
   parameter int WIDTH = 32,
   parameter int KW    = 1
) (
   input  logic [WIDTH-1:0] d,
   input  logic [KW-1:0]    k,
   input  logic [2:0]       op,
   input  logic             fill,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] sra, rol, ror;
   always_comb begin
      sra = fill ? ~(~d >> k) : d >> k;
      rol = (d << k) | (d >> (WIDTH - int'(k)));
      ror = (d >> k) | (d << (WIDTH - int'(k)));
      q = op == OP_SLL ? d << k :
          op == OP_SRL ? d >> k :
          op == OP_SRA ? sra :
          op == OP_ROL ? rol :
          op == OP_ROR ? ror : d;
   end
endmodule

// File: rtl/shift_unit.sv
// shift_unit: source-selected SLL/SRL/SRA/ROL/ROR done STEP bits per cycle with start/busy/done handshake
module shift_unit import shift_pkg::*; #(
   parameter int WIDTH     = 32,
   parameter int SHAMT_W   = $clog2(WIDTH),
   parameter int STEP      = 1,
   parameter int IMM_SHIFT = IMM_SHIFT_DEF
) (
   input logic         clk,
   input logic         reset_n,
   shift_unit_if.slave bus
);
   localparam int RW = SHAMT_W > $clog2(IMM_SHIFT + 1) ? SHAMT_W : $clog2(IMM_SHIFT + 1);
   localparam int KW = $clog2(STEP + 1);
   localparam logic [1:0] S_IDLE  = ST_IDLE;
   localparam logic [1:0] S_SHIFT = ST_SHIFT;
   localparam logic [1:0] S_DONE  = ST_DONE;
   logic [1:0]       state;
   logic [WIDTH-1:0] work, opnd, stepped, result;
   logic [RW-1:0]    rem, amt;
   logic [KW-1:0]    k;
   logic [2:0]       op;
   logic             fill, accept, bad, illegal, done;
   always_comb begin
      bad = op_illegal(bus.op_i);
      opnd = bus.src_sel_i == SRC_AB  ? bus.a_i :
             bus.src_sel_i == SRC_LUI ? WIDTH'(bus.imm_i) : bus.b_i;
      amt = bad                        ? '0 :
            bus.src_sel_i == SRC_AB    ? RW'(bus.b_i[SHAMT_W-1:0]) :
            bus.src_sel_i == SRC_BIMM  ? RW'(bus.imm_i[SHAMT_W-1:0]) :
            bus.src_sel_i == SRC_LUI   ? RW'(IMM_SHIFT) : RW'(bus.a_i[SHAMT_W-1:0]);
      accept = bus.start_i && state != S_SHIFT;
      k = rem > RW'(STEP) ? KW'(STEP) : KW'(rem);
   end
   shift_step #(.WIDTH(WIDTH), .KW(KW)) u_step (
      .d    (work),
      .k    (k),
      .op   (op),
      .fill (fill),
      .q    (stepped)
   );
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state   <= S_IDLE;
         work    <= '0;
         rem     <= '0;
         op      <= '0;
         fill    <= 1'b0;
         result  <= '0;
         illegal <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            work  <= opnd;
            rem   <= amt;
            op    <= bus.op_i;
            fill  <= opnd[WIDTH-1];
            state <= amt == '0 ? S_DONE : S_SHIFT;
            if (amt == '0) begin
               result  <= opnd;
               illegal <= bad;
               done    <= 1'b1;
            end
         end else if (state == S_SHIFT) begin
            work <= stepped;
            rem  <= rem - RW'(k);
            if (rem == RW'(k)) begin
               state   <= S_DONE;
               result  <= stepped;
               illegal <= 1'b0;
               done    <= 1'b1;
            end
         end else if (state == S_DONE)
            state <= S_IDLE;
      end
   assign bus.busy_o    = state == S_SHIFT;
   assign bus.done_o    = done;
   assign bus.result_o  = result;
   assign bus.illegal_o = illegal;
endmodule

// File: tb/tb_shift_unit.sv
// tb_shift_unit: STEP=1/4/8 shift units driven in lockstep, checked against table vectors and a reference model
module tb_shift_unit;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [1:0]  sel;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic [15:0] imm;
   int          checks = 0;
   int          errors = 0;
   logic        busy_w [3];
   logic        done_w [3];
   logic        ill_w  [3];
   logic [31:0] res_w  [3];

   always #5 clk = ~clk;

   shift_unit_if #(.WIDTH(32)) sif [3] ();

   for (genvar g = 0; g < 3; g++) begin : g_dut
      assign sif[g].start_i   = start;
      assign sif[g].src_sel_i = sel;
      assign sif[g].op_i      = op;
      assign sif[g].a_i       = a;
      assign sif[g].b_i       = b;
      assign sif[g].imm_i     = imm;
      assign busy_w[g] = sif[g].busy_o;
      assign done_w[g] = sif[g].done_o;
      assign ill_w[g]  = sif[g].illegal_o;
      assign res_w[g]  = sif[g].result_o;
      shift_unit #(.WIDTH(32), .STEP(g == 0 ? 1 : g == 1 ? 4 : 8)) dut (
         .clk     (clk),
         .reset_n (reset_n),
         .bus     (sif[g])
      );
   end

   function automatic int stp(input int i);
      return i == 0 ? 1 : i == 1 ? 4 : 8;
   endfunction

   function automatic int m_amt(input logic [1:0] s, input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv, input logic [15:0] iv);
      if (o > 3'd4) return 0;
      case (s)
         2'd0:    return int'(bv[4:0]);
         2'd1:    return int'(iv[4:0]);
         2'd2:    return 16;
         default: return int'(av[4:0]);
      endcase
   endfunction

   function automatic logic [31:0] m_res(input logic [1:0] s, input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv, input logic [15:0] iv);
      logic [31:0] x, y;
      int n;
      n = m_amt(s, o, av, bv, iv);
      x = s == 2'd0 ? av : s == 2'd2 ? {16'h0, iv} : bv;
      y = x;
      case (o)
         3'd0: y = x << n;
         3'd1: y = x >> n;
         3'd2: y = $signed(x) >>> n;
         3'd3: for (int j = 0; j < 32; j++) y[(j + n) % 32] = x[j];
         3'd4: for (int j = 0; j < 32; j++) y[j] = x[(j + n) % 32];
         default: y = x;
      endcase
      return y;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic go(input logic [1:0] s, input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv, input logic [15:0] iv);
      @(negedge clk);
      sel = s; op = o; a = av; b = bv; imm = iv; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      sel = 2'($urandom); op = 3'($urandom); a = $urandom; b = $urandom; imm = 16'($urandom);
   endtask

   // called just after the accepting edge; cycle 1 is the first negedge that follows
   task automatic await_op(input logic [31:0] er, input logic ei, input int n, input int poke, input string tag);
      int el[3], lat[3], nd[3], nb[3];
      logic [31:0] gr[3];
      logic gi[3];
      int mx;
      mx = 0;
      for (int i = 0; i < 3; i++) begin
         el[i] = (n + stp(i) - 1) / stp(i) + 1;
         lat[i] = 0; nd[i] = 0; nb[i] = 0; gr[i] = '0; gi[i] = 1'b0;
         if (el[i] > mx) mx = el[i];
      end
      for (int c = 1; c <= mx + 2; c++) begin
         @(negedge clk);
         if (c == poke) begin
            start = 1'b1; op = 3'($urandom); a = $urandom; b = $urandom;
         end else start = 1'b0;
         for (int i = 0; i < 3; i++) begin
            if (busy_w[i]) nb[i]++;
            if (done_w[i]) begin
               nd[i]++;
               if (lat[i] == 0) begin
                  lat[i] = c; gr[i] = res_w[i]; gi[i] = ill_w[i];
               end
            end
         end
      end
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s latency step%0d", tag, stp(i)), lat[i], el[i]);
         chk($sformatf("%s done count step%0d", tag, stp(i)), nd[i], 1);
         chk($sformatf("%s busy cycles step%0d", tag, stp(i)), nb[i], el[i] - 1);
         chk($sformatf("%s result step%0d", tag, stp(i)), gr[i], er);
         chk($sformatf("%s illegal step%0d", tag, stp(i)), 32'(gi[i]), 32'(ei));
      end
   endtask

   typedef struct {
      logic [1:0]  sel;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [15:0] imm;
      logic [31:0] res;
      logic        ill;
      int          amt;
   } vec_t;

   vec_t vt [8];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vt[0] = '{2'd0, 3'd0, 32'h0000_0001, 32'd31,        16'h0000, 32'h8000_0000, 1'b0, 31};
      vt[1] = '{2'd1, 3'd2, 32'h0000_0000, 32'h8000_00F0, 16'h0007, 32'hFF00_0001, 1'b0, 7};
      vt[2] = '{2'd2, 3'd0, 32'h0000_0000, 32'h0000_0000, 16'h1234, 32'h1234_0000, 1'b0, 16};
      vt[3] = '{2'd0, 3'd1, 32'hDEAD_BEEF, 32'h0000_0020, 16'h0000, 32'hDEAD_BEEF, 1'b0, 0};
      vt[4] = '{2'd0, 3'd4, 32'h0000_000F, 32'd4,         16'h0000, 32'hF000_0000, 1'b0, 4};
      vt[5] = '{2'd0, 3'd7, 32'h1234_5678, 32'd5,         16'h0000, 32'h1234_5678, 1'b1, 0};
      vt[6] = '{2'd3, 3'd3, 32'h0000_0001, 32'h8000_0001, 16'h0000, 32'h0000_0003, 1'b0, 1};
      vt[7] = '{2'd1, 3'd2, 32'h0000_0000, 32'h7000_0000, 16'hFFFF, 32'h0000_0000, 1'b0, 31};
      reset_n = 1'b0; start = 1'b0; sel = '0; op = '0; a = '0; b = '0; imm = '0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reset busy step%0d", stp(i)), 32'(busy_w[i]), 32'd0);
         chk($sformatf("reset done step%0d", stp(i)), 32'(done_w[i]), 32'd0);
         chk($sformatf("reset illegal step%0d", stp(i)), 32'(ill_w[i]), 32'd0);
         chk($sformatf("reset result step%0d", stp(i)), res_w[i], 32'd0);
      end
      reset_n = 1'b1;
      for (int r = 0; r < 8; r++) begin
         go(vt[r].sel, vt[r].op, vt[r].a, vt[r].b, vt[r].imm);
         await_op(vt[r].res, vt[r].ill, vt[r].amt, 0, $sformatf("vec%0d", r));
      end
      // zero-amount op, then a rotate accepted in its done cycle
      go(2'd0, 3'd1, 32'hDEAD_BEEF, 32'h0000_0020, 16'h0);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("b2b first done step%0d", stp(i)), 32'(done_w[i]), 32'd1);
         chk($sformatf("b2b first result step%0d", stp(i)), res_w[i], 32'hDEAD_BEEF);
      end
      sel = 2'd0; op = 3'd4; a = 32'h0000_000F; b = 32'd4; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("b2b result held", res_w[0], 32'hDEAD_BEEF);
      chk("b2b busy after accept", 32'(busy_w[0]), 32'd1);
      a = $urandom; b = $urandom;
      await_op(32'hF000_0000, 1'b0, 4, 0, "b2b second");
      // start raised mid-shift must be dropped
      go(2'd0, 3'd0, 32'h0000_0001, 32'd31, 16'h0);
      await_op(32'h8000_0000, 1'b0, 31, 2, "ignored start");
      // reset in the middle of a shift
      go(2'd0, 3'd0, 32'h0000_0001, 32'd31, 16'h0);
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++)
         chk($sformatf("midreset outputs step%0d", stp(i)), {res_w[i][28:0], busy_w[i], done_w[i], ill_w[i]} | 32'(res_w[i][31:29] != 3'd0), 32'd0);
      begin
         int nd;
         nd = 0;
         repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (done_w[i]) nd++;
         end
         chk("midreset no done", nd, 0);
      end
      reset_n = 1'b1;
      go(2'd1, 3'd4, 32'h0, 32'h1234_5678, 16'h0008);
      await_op(m_res(2'd1, 3'd4, 32'h0, 32'h1234_5678, 16'h0008), 1'b0, 8, 0, "post reset");
      for (int r = 0; r < 40; r++) begin
         logic [1:0]  s;
         logic [2:0]  o;
         logic [31:0] av, bv;
         logic [15:0] iv;
         s = 2'($urandom_range(0, 3));
         o = 3'($urandom_range(0, 7));
         av = $urandom; bv = $urandom; iv = 16'($urandom);
         go(s, o, av, bv, iv);
         await_op(m_res(s, o, av, bv, iv), o > 3'd4, m_amt(s, o, av, bv, iv), 0, $sformatf("rnd%0d", r));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
